// File: rtl/cmp_pkg.sv
// Shared definitions for the comparator arbiter: comparator result codes
// and the sequencer state encoding.
package cmp_pkg;

  localparam logic [15:0] CMP_EQ = 16'h0000;
  localparam logic [15:0] CMP_GT = 16'h0001;
  localparam logic [15:0] CMP_LT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } cmp_state_t;

endpackage

// File: rtl/cmp_arbiter_if.sv
// Requester bus and shared-comparator wiring for cmp_arbiter.
// slave = arbiter side, master = requesters/comparator side.
interface cmp_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16
);
  import cmp_pkg::*;

  logic [NREQ-1:0]             req;
  logic [NREQ-1:0][WIDTH-1:0]  op_a;
  logic [NREQ-1:0][WIDTH-1:0]  op_b;
  logic [NREQ-1:0]             gnt;
  logic [NREQ-1:0]             resp_valid;
  logic [WIDTH-1:0]            resp_result;
  logic                        busy;
  logic [WIDTH-1:0]            cmp_num1;
  logic [WIDTH-1:0]            cmp_num2;
  logic [WIDTH-1:0]            cmp_result;

  modport slave (
    input  req, op_a, op_b, cmp_result,
    output gnt, resp_valid, resp_result, busy, cmp_num1, cmp_num2
  );

  modport master (
    output req, op_a, op_b, cmp_result,
    input  gnt, resp_valid, resp_result, busy, cmp_num1, cmp_num2
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: searches req starting one past the
// last winner (wrapping modulo NREQ) and returns the first hit.
module rr_picker #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] win,
  output logic [IW-1:0]   win_id,
  output logic            any_req
);
  import cmp_pkg::*;

  logic          found;
  logic [IW-1:0] cand;

  // Rotating priority search; lowest offset from last+1 wins.
  always_comb begin
    found   = 1'b0;
    cand    = '0;
    win_id  = '0;
    any_req = |req;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IW'((int'(last) + i) % NREQ);
      if (!found && req[cand]) begin
        found  = 1'b1;
        win_id = cand;
      end
    end
    win = any_req ? (NREQ'(1) << win_id) : '0;
  end

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter/sequencer for one shared combinational comparator.
// A grant latches the winner's operands straight into the comparator
// drive registers; the result is captured at the end of ISSUE and
// returned with a one-cycle strobe in RESP.
module cmp_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  cmp_arbiter_if.slave  bus
);
  import cmp_pkg::*;

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  cmp_state_t       state;
  logic [IW-1:0]    last;
  logic [NREQ-1:0]  gnt_q;
  logic [NREQ-1:0]  resp_valid_q;
  logic [WIDTH-1:0] resp_result_q;
  logic [WIDTH-1:0] num1_q;
  logic [WIDTH-1:0] num2_q;

  logic [NREQ-1:0]  win;
  logic [IW-1:0]    win_id;
  logic             any_req;

  rr_picker #(.NREQ(NREQ), .IW(IW)) u_picker (
    .req     (bus.req),
    .last    (last),
    .win     (win),
    .win_id  (win_id),
    .any_req (any_req)
  );

  // Sequencer: IDLE -> ISSUE -> RESP -> IDLE with all outputs registered.
  // gnt_q stays one-hot for the whole ISSUE cycle and is reused as the
  // response address, so no separate id register is needed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      last          <= IW'(NREQ - 1);
      gnt_q         <= '0;
      resp_valid_q  <= '0;
      resp_result_q <= '0;
      num1_q        <= '0;
      num2_q        <= '0;
    end else begin
      case (state)
        IDLE: begin
          resp_valid_q <= '0;
          if (any_req) begin
            gnt_q  <= win;
            last   <= win_id;
            num1_q <= bus.op_a[win_id];
            num2_q <= bus.op_b[win_id];
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          gnt_q         <= '0;
          resp_valid_q  <= gnt_q;
          resp_result_q <= bus.cmp_result;
          state         <= RESP;
        end
        RESP: begin
          resp_valid_q <= '0;
          state        <= IDLE;
        end
        default: begin
          gnt_q        <= '0;
          resp_valid_q <= '0;
          state        <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_result = resp_result_q;
  assign bus.cmp_num1    = num1_q;
  assign bus.cmp_num2    = num2_q;
  assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed bench for cmp_arbiter with a behavioural unsigned comparator
// standing in for the shared comparator.
module tb_cmp_arbiter;
  import cmp_pkg::*;

  localparam int NREQ  = 4;
  localparam int WIDTH = 16;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  cmp_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  cmp_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.cmp_result = (bus.cmp_num1 == bus.cmp_num2) ? CMP_EQ :
                          (bus.cmp_num1 >  bus.cmp_num2) ? CMP_GT : CMP_LT;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated transaction from requester idx with a hand-computed result.
  task automatic do_op(input int idx, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] exp_res, input string tag);
    logic [3:0] oh;
    oh = 4'(1 << idx);
    bus.op_a[idx] = a;
    bus.op_b[idx] = b;
    bus.req = oh;
    tick();
    check_eq({tag, "_gnt"}, 32'(bus.gnt), 32'(oh));
    check_eq({tag, "_num1"}, 32'(bus.cmp_num1), 32'(a));
    check_eq({tag, "_num2"}, 32'(bus.cmp_num2), 32'(b));
    bus.req = '0;
    tick();
    check_eq({tag, "_rv"}, 32'(bus.resp_valid), 32'(oh));
    check_eq({tag, "_res"}, 32'(bus.resp_result), 32'(exp_res));
    tick();
    check_eq({tag, "_idle_busy"}, 32'(bus.busy), 32'(0));
    check_eq({tag, "_hold_num1"}, 32'(bus.cmp_num1), 32'(a));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.req  = 4'b1111;
    bus.op_a = '0;
    bus.op_b = '0;
    #1;

    // Reset held two cycles with all requests high.
    tick();
    tick();
    check_eq("rst_gnt",  32'(bus.gnt), 32'(0));
    check_eq("rst_rv",   32'(bus.resp_valid), 32'(0));
    check_eq("rst_res",  32'(bus.resp_result), 32'(0));
    check_eq("rst_num1", 32'(bus.cmp_num1), 32'(0));
    check_eq("rst_num2", 32'(bus.cmp_num2), 32'(0));
    check_eq("rst_busy", 32'(bus.busy), 32'(0));
    rst_n = 1'b1;
    tick();
    check_eq("first_gnt", 32'(bus.gnt), 32'(4'b0001));
    check_eq("first_busy", 32'(bus.busy), 32'(1));
    bus.req = '0;
    tick();
    check_eq("first_rv", 32'(bus.resp_valid), 32'(4'b0001));
    check_eq("first_res", 32'(bus.resp_result), 32'(CMP_EQ));
    tick();

    // Single requester 2, three result codes.
    do_op(2, 16'd1, 16'd1, 16'h0000, "eq");
    do_op(2, 16'd4, 16'd1, 16'h0001, "gt");
    do_op(2, 16'd1, 16'd4, 16'hFFFF, "lt");
    do_op(0, 16'hFFFF, 16'h0001, 16'h0001, "unsigned_gt");

    // All four held high from reset: grants 0,1,2,3 spaced three cycles.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.req = 4'b1111;
    for (int c = 0; c < 12; c++) begin
      tick();
      check_eq($sformatf("rr_gnt_c%0d", c), 32'(bus.gnt),
               32'((c % 3 == 0) ? (1 << (c / 3)) : 0));
      check_eq($sformatf("rr_rv_c%0d", c), 32'(bus.resp_valid),
               32'((c % 3 == 1) ? (1 << (c / 3)) : 0));
    end
    bus.req = '0;
    tick();

    // Operands change after grant: latched 4 vs 1 must still give GT.
    bus.op_a[1] = 16'd4;
    bus.op_b[1] = 16'd1;
    bus.req = 4'b0010;
    tick();
    check_eq("latch_gnt", 32'(bus.gnt), 32'(4'b0010));
    bus.op_a[1] = 16'd0;
    bus.req = '0;
    tick();
    check_eq("latch_rv", 32'(bus.resp_valid), 32'(4'b0010));
    check_eq("latch_res", 32'(bus.resp_result), 32'(16'h0001));
    tick();

    // Reset during ISSUE aborts the operation and restores priority.
    bus.op_a[0] = 16'd5;
    bus.op_b[0] = 16'd3;
    bus.req = 4'b0001;
    tick();
    check_eq("abort_gnt", 32'(bus.gnt), 32'(4'b0001));
    rst_n = 1'b0;
    bus.req = '0;
    tick();
    check_eq("abort_rv", 32'(bus.resp_valid), 32'(0));
    check_eq("abort_busy", 32'(bus.busy), 32'(0));
    check_eq("abort_gnt0", 32'(bus.gnt), 32'(0));
    rst_n = 1'b1;
    tick();
    check_eq("abort_rv_after", 32'(bus.resp_valid), 32'(0));
    bus.req = 4'b1111;
    tick();
    check_eq("abort_last_gnt", 32'(bus.gnt), 32'(4'b0001));
    bus.req = '0;
    tick();
    check_eq("abort_last_rv", 32'(bus.resp_valid), 32'(4'b0001));

    // Requester 3 rises during requester 0's RESP: granted two cycles later.
    bus.op_a[3] = 16'd2;
    bus.op_b[3] = 16'd9;
    bus.req = 4'b1000;
    tick();
    check_eq("late_idle_gnt", 32'(bus.gnt), 32'(0));
    tick();
    check_eq("late_gnt", 32'(bus.gnt), 32'(4'b1000));
    bus.req = '0;
    tick();
    check_eq("late_rv", 32'(bus.resp_valid), 32'(4'b1000));
    check_eq("late_res", 32'(bus.resp_result), 32'(16'hFFFF));
    tick();
    check_eq("late_rv_pulse", 32'(bus.resp_valid), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
